// File: rtl/accelerator_read_weighting.sv
// -----------------------------------------------------------------------------
// accelerator_read_weighting
//
// Purpose:
//   Computes the read weighting of a memory-augmented network, element by
//   element:  w[i] = pi0*b[i] + pi1*c[i] + pi2*f[i],  i = 0..N-1.
//   The three read-mode weights (pi) arrive first, in the order backward,
//   content, forward. After that the backward, content and forward elements
//   for each index arrive on independent strobes. Arithmetic is unsigned and
//   truncated to DATA_SIZE bits, so every product and sum wraps.
//
// Parameters:
//   DATA_SIZE     width of every data word
//   CONTROL_SIZE  control width, kept for interface compatibility (no effect)
//
// Ports:
//   CLK            rising-edge clock
//   RST            synchronous, active-low reset
//   START          pulse that begins one operation (honoured only when idle)
//   READY          one-cycle completion pulse
//   PI_IN_ENABLE   qualifies PI_IN (three pulses: backward, content, forward)
//   B_IN_ENABLE    qualifies B_IN, backward element i
//   C_IN_ENABLE    qualifies C_IN, content element i
//   F_IN_ENABLE    qualifies F_IN, forward element i
//   W_OUT_ENABLE   one-cycle strobe qualifying W_OUT
//   SIZE_N_IN      number of memory locations N
//   PI_IN          read-mode weight
//   B_IN/C_IN/F_IN backward, content and forward elements
//   W_OUT          read weighting element w[i]; holds between strobes
// -----------------------------------------------------------------------------
module accelerator_read_weighting #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,

  input  logic                 START,
  output logic                 READY,

  input  logic                 PI_IN_ENABLE,
  input  logic                 B_IN_ENABLE,
  input  logic                 C_IN_ENABLE,
  input  logic                 F_IN_ENABLE,
  output logic                 W_OUT_ENABLE,

  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] PI_IN,
  input  logic [DATA_SIZE-1:0] B_IN,
  input  logic [DATA_SIZE-1:0] C_IN,
  input  logic [DATA_SIZE-1:0] F_IN,
  output logic [DATA_SIZE-1:0] W_OUT
);

  // CONTROL_SIZE only exists so this block drops into the same parameter
  // list as its sibling stages; nothing inside depends on its value.
  if (CONTROL_SIZE < 1) begin : g_control_size_unused
  end

  typedef enum logic [2:0] {
    STARTER = 3'd0,
    PI      = 3'd1,
    INPUT   = 3'd2,
    OUTPUT  = 3'd3,
    ENDER   = 3'd4
  } state_t;

  state_t               state;

  logic [DATA_SIZE-1:0] size_n;
  logic [DATA_SIZE-1:0] index;
  logic [1:0]           pi_cnt;

  logic [DATA_SIZE-1:0] pi0;
  logic [DATA_SIZE-1:0] pi1;
  logic [DATA_SIZE-1:0] pi2;

  logic [DATA_SIZE-1:0] b_data;
  logic [DATA_SIZE-1:0] c_data;
  logic [DATA_SIZE-1:0] f_data;
  logic                 b_valid;
  logic                 c_valid;
  logic                 f_valid;

  logic [DATA_SIZE-1:0] w_sum;
  logic                 all_valid;
  logic                 last_index;

  // Weighted sum of the latched element. Every operand is DATA_SIZE wide,
  // so the products and the sum are evaluated at DATA_SIZE bits and wrap.
  always_comb begin
    w_sum = (pi0 * b_data) + (pi1 * c_data) + (pi2 * f_data);
  end

  // An element is complete when every input is either already latched or
  // arriving this very cycle, so the last strobe does not cost an extra cycle.
  always_comb begin
    all_valid  = (b_valid | B_IN_ENABLE) & (c_valid | C_IN_ENABLE) & (f_valid | F_IN_ENABLE);
    last_index = (index == (size_n - DATA_SIZE'(1)));
  end

  // Main controller. READY and W_OUT_ENABLE default low every cycle and are
  // raised only from ENDER and OUTPUT respectively, which keeps both of them
  // single-cycle pulses that appear the cycle after those states.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= STARTER;
      READY        <= 1'b0;
      W_OUT_ENABLE <= 1'b0;
      W_OUT        <= '0;
      size_n       <= '0;
      index        <= '0;
      pi_cnt       <= 2'd0;
      pi0          <= '0;
      pi1          <= '0;
      pi2          <= '0;
      b_data       <= '0;
      c_data       <= '0;
      f_data       <= '0;
      b_valid      <= 1'b0;
      c_valid      <= 1'b0;
      f_valid      <= 1'b0;
    end else begin
      READY        <= 1'b0;
      W_OUT_ENABLE <= 1'b0;

      case (state)
        STARTER: begin
          if (START) begin
            size_n  <= SIZE_N_IN;
            index   <= '0;
            pi_cnt  <= 2'd0;
            b_valid <= 1'b0;
            c_valid <= 1'b0;
            f_valid <= 1'b0;
            // An empty memory has nothing to weight; finish straight away.
            if (SIZE_N_IN == '0) begin
              state <= ENDER;
            end else begin
              state <= PI;
            end
          end
        end

        PI: begin
          if (PI_IN_ENABLE) begin
            case (pi_cnt)
              2'd0:    pi0 <= PI_IN;
              2'd1:    pi1 <= PI_IN;
              default: pi2 <= PI_IN;
            endcase
            pi_cnt <= pi_cnt + 2'd1;
            if (pi_cnt == 2'd2) begin
              state <= INPUT;
            end
          end
        end

        INPUT: begin
          // Each strobe is independent; a repeat simply overwrites.
          if (B_IN_ENABLE) begin
            b_data  <= B_IN;
            b_valid <= 1'b1;
          end
          if (C_IN_ENABLE) begin
            c_data  <= C_IN;
            c_valid <= 1'b1;
          end
          if (F_IN_ENABLE) begin
            f_data  <= F_IN;
            f_valid <= 1'b1;
          end
          if (all_valid) begin
            state <= OUTPUT;
          end
        end

        OUTPUT: begin
          W_OUT        <= w_sum;
          W_OUT_ENABLE <= 1'b1;
          b_valid      <= 1'b0;
          c_valid      <= 1'b0;
          f_valid      <= 1'b0;
          if (last_index) begin
            state <= ENDER;
          end else begin
            index <= index + DATA_SIZE'(1);
            state <= INPUT;
          end
        end

        ENDER: begin
          READY <= 1'b1;
          state <= STARTER;
        end

        default: begin
          state <= STARTER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_read_weighting.sv
// -----------------------------------------------------------------------------
// tb_accelerator_read_weighting
//
// Directed bench for accelerator_read_weighting. Inputs are driven and
// outputs sampled on the falling edge of CLK, so every observation happens
// half a cycle away from the capturing rising edge.
// -----------------------------------------------------------------------------
module tb_accelerator_read_weighting;

  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          READY;
  logic          PI_IN_ENABLE;
  logic          B_IN_ENABLE;
  logic          C_IN_ENABLE;
  logic          F_IN_ENABLE;
  logic          W_OUT_ENABLE;
  logic [DW-1:0] SIZE_N_IN;
  logic [DW-1:0] PI_IN;
  logic [DW-1:0] B_IN;
  logic [DW-1:0] C_IN;
  logic [DW-1:0] F_IN;
  logic [DW-1:0] W_OUT;

  int checks = 0;
  int errors = 0;

  accelerator_read_weighting #(
    .DATA_SIZE   (DW),
    .CONTROL_SIZE(64)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .READY        (READY),
    .PI_IN_ENABLE (PI_IN_ENABLE),
    .B_IN_ENABLE  (B_IN_ENABLE),
    .C_IN_ENABLE  (C_IN_ENABLE),
    .F_IN_ENABLE  (F_IN_ENABLE),
    .W_OUT_ENABLE (W_OUT_ENABLE),
    .SIZE_N_IN    (SIZE_N_IN),
    .PI_IN        (PI_IN),
    .B_IN         (B_IN),
    .C_IN         (C_IN),
    .F_IN         (F_IN),
    .W_OUT        (W_OUT)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    START        = 1'b0;
    PI_IN_ENABLE = 1'b0;
    B_IN_ENABLE  = 1'b0;
    C_IN_ENABLE  = 1'b0;
    F_IN_ENABLE  = 1'b0;
    SIZE_N_IN    = '0;
    PI_IN        = '0;
    B_IN         = '0;
    C_IN         = '0;
    F_IN         = '0;
  endtask

  task automatic do_start(input logic [DW-1:0] n);
    START     = 1'b1;
    SIZE_N_IN = n;
    step();
    START     = 1'b0;
  endtask

  task automatic load_pi(input logic [DW-1:0] p0, input logic [DW-1:0] p1, input logic [DW-1:0] p2);
    PI_IN_ENABLE = 1'b1;
    PI_IN = p0;
    step();
    PI_IN = p1;
    step();
    PI_IN = p2;
    step();
    PI_IN_ENABLE = 1'b0;
  endtask

  task automatic drive_b(input logic [DW-1:0] v);
    B_IN_ENABLE = 1'b1;
    B_IN = v;
    step();
    B_IN_ENABLE = 1'b0;
  endtask

  task automatic drive_c(input logic [DW-1:0] v);
    C_IN_ENABLE = 1'b1;
    C_IN = v;
    step();
    C_IN_ENABLE = 1'b0;
  endtask

  task automatic drive_f(input logic [DW-1:0] v);
    F_IN_ENABLE = 1'b1;
    F_IN = v;
    step();
    F_IN_ENABLE = 1'b0;
  endtask

  task automatic drive_all(input logic [DW-1:0] b, input logic [DW-1:0] c, input logic [DW-1:0] f);
    B_IN_ENABLE = 1'b1;
    C_IN_ENABLE = 1'b1;
    F_IN_ENABLE = 1'b1;
    B_IN = b;
    C_IN = c;
    F_IN = f;
    step();
    B_IN_ENABLE = 1'b0;
    C_IN_ENABLE = 1'b0;
    F_IN_ENABLE = 1'b0;
  endtask

  // Reset values, both while held and just after release with idle inputs.
  task automatic test_reset();
    RST = 1'b0;
    idle_inputs();
    step();
    step();
    checks++; if (READY !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", READY); end
    checks++; if (W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL reset_woe: got %b expected 0", W_OUT_ENABLE); end
    checks++; if (W_OUT !== 64'd0) begin errors++; $display("[TB] FAIL reset_wout: got %0d expected 0", W_OUT); end
    RST = 1'b1;
    step();
    step();
    checks++; if (READY !== 1'b0 || W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: got ready=%b woe=%b expected 0/0", READY, W_OUT_ENABLE); end
  endtask

  // N=2, pi=(1,2,3): w0 = 4+12+24 = 40, w1 = 5+14+27 = 46.
  task automatic test_basic();
    do_start(64'd2);
    load_pi(64'd1, 64'd2, 64'd3);
    drive_b(64'd4);
    drive_c(64'd6);
    drive_f(64'd8);
    checks++; if (W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL basic_w0_early: got %b expected 0", W_OUT_ENABLE); end
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1) begin errors++; $display("[TB] FAIL basic_w0_strobe: got %b expected 1", W_OUT_ENABLE); end
    checks++; if (W_OUT !== 64'd40) begin errors++; $display("[TB] FAIL basic_w0_value: got %0d expected 40", W_OUT); end
    drive_b(64'd5);
    checks++; if (W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL basic_w0_single: got %b expected 0", W_OUT_ENABLE); end
    checks++; if (W_OUT !== 64'd40) begin errors++; $display("[TB] FAIL basic_w0_hold: got %0d expected 40", W_OUT); end
    drive_c(64'd7);
    drive_f(64'd9);
    checks++; if (W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL basic_w1_early: got %b expected 0", W_OUT_ENABLE); end
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1) begin errors++; $display("[TB] FAIL basic_w1_strobe: got %b expected 1", W_OUT_ENABLE); end
    checks++; if (W_OUT !== 64'd46) begin errors++; $display("[TB] FAIL basic_w1_value: got %0d expected 46", W_OUT); end
    checks++; if (READY !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_early: got %b expected 0", READY); end
    step();
    checks++; if (READY !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b expected 1", READY); end
    checks++; if (W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL basic_woe_after: got %b expected 0", W_OUT_ENABLE); end
    checks++; if (W_OUT !== 64'd46) begin errors++; $display("[TB] FAIL basic_w1_hold: got %0d expected 46", W_OUT); end
    step();
    checks++; if (READY !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_single: got %b expected 0", READY); end
  endtask

  // Element 0 as f,c,b on separate cycles with a stray PI strobe; element 1
  // with all three strobes sharing one cycle.
  task automatic test_ordering();
    do_start(64'd2);
    load_pi(64'd1, 64'd2, 64'd3);
    PI_IN_ENABLE = 1'b1;
    PI_IN = 64'd100;
    step();
    PI_IN_ENABLE = 1'b0;
    drive_f(64'd8);
    drive_c(64'd6);
    drive_b(64'd4);
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd40) begin errors++; $display("[TB] FAIL order_w0: got woe=%b w=%0d expected 1/40", W_OUT_ENABLE, W_OUT); end
    drive_all(64'd5, 64'd7, 64'd9);
    checks++; if (W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL order_w1_early: got %b expected 0", W_OUT_ENABLE); end
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd46) begin errors++; $display("[TB] FAIL order_w1: got woe=%b w=%0d expected 1/46", W_OUT_ENABLE, W_OUT); end
    step();
    checks++; if (READY !== 1'b1) begin errors++; $display("[TB] FAIL order_ready: got %b expected 1", READY); end
  endtask

  // pi0 = 2^63, b0 = 2 -> product wraps to 0; c0 overwritten 5 -> 9; w = 9.
  task automatic test_wrap_overwrite();
    do_start(64'd1);
    load_pi(64'h8000_0000_0000_0000, 64'd1, 64'd0);
    drive_b(64'd2);
    drive_c(64'd5);
    drive_c(64'd9);
    drive_f(64'd1);
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd9) begin errors++; $display("[TB] FAIL wrap_value: got woe=%b w=%0d expected 1/9", W_OUT_ENABLE, W_OUT); end
    step();
    checks++; if (READY !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready: got %b expected 1", READY); end
  endtask

  // N=0: no output strobe, READY two cycles after START.
  task automatic test_empty();
    do_start(64'd0);
    checks++; if (READY !== 1'b0 || W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL empty_early: got ready=%b woe=%b expected 0/0", READY, W_OUT_ENABLE); end
    step();
    checks++; if (READY !== 1'b1 || W_OUT_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL empty_ready: got ready=%b woe=%b expected 1/0", READY, W_OUT_ENABLE); end
    step();
    checks++; if (READY !== 1'b0) begin errors++; $display("[TB] FAIL empty_ready_single: got %b expected 0", READY); end
  endtask

  // START ignored while busy; reset aborts an N=3 run; a fresh run works.
  task automatic test_busy_abort();
    do_start(64'd3);
    load_pi(64'd1, 64'd1, 64'd1);
    START = 1'b1;
    SIZE_N_IN = 64'd1;
    step();
    START = 1'b0;
    drive_all(64'd1, 64'd2, 64'd3);
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd6) begin errors++; $display("[TB] FAIL busy_w0: got woe=%b w=%0d expected 1/6", W_OUT_ENABLE, W_OUT); end
    RST = 1'b0;
    step();
    RST = 1'b1;
    checks++; if (W_OUT !== 64'd0 || W_OUT_ENABLE !== 1'b0 || READY !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs: got w=%0d woe=%b ready=%b expected 0/0/0", W_OUT, W_OUT_ENABLE, READY); end
    PI_IN_ENABLE = 1'b1;
    B_IN_ENABLE = 1'b1;
    C_IN_ENABLE = 1'b1;
    F_IN_ENABLE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (W_OUT_ENABLE !== 1'b0 || READY !== 1'b0) begin errors++; $display("[TB] FAIL abort_quiet_%0d: got woe=%b ready=%b expected 0/0", i, W_OUT_ENABLE, READY); end
    end
    idle_inputs();
    step();
    do_start(64'd3);
    load_pi(64'd2, 64'd3, 64'd4);
    drive_all(64'd1, 64'd1, 64'd1);
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd9) begin errors++; $display("[TB] FAIL rerun_w0: got woe=%b w=%0d expected 1/9", W_OUT_ENABLE, W_OUT); end
    drive_b(64'd2);
    drive_c(64'd0);
    drive_f(64'd1);
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd8) begin errors++; $display("[TB] FAIL rerun_w1: got woe=%b w=%0d expected 1/8", W_OUT_ENABLE, W_OUT); end
    drive_all(64'd10, 64'd20, 64'd30);
    step();
    checks++; if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'd200 || READY !== 1'b0) begin errors++; $display("[TB] FAIL rerun_w2: got woe=%b w=%0d ready=%b expected 1/200/0", W_OUT_ENABLE, W_OUT, READY); end
    step();
    checks++; if (READY !== 1'b1) begin errors++; $display("[TB] FAIL rerun_ready: got %b expected 1", READY); end
  endtask

  initial begin
    $display("[TB] accelerator_read_weighting directed tests");
    test_reset();
    test_basic();
    step();
    test_ordering();
    step();
    test_wrap_overwrite();
    step();
    test_empty();
    step();
    test_busy_abort();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
